// File: rtl/pes_uart_pkg.sv
// Shared constants and drain-FSM state encoding for the uart transmit path.
package pes_uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } drain_state_e;

endpackage

// File: rtl/pes_uart_tx_fifo_if.sv
// Producer-side and uart-side signals of the tx FIFO, grouped for port use.
interface pes_uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  import pes_uart_pkg::*;

  logic [UART_DATA_W-1:0] wr_data;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADDR_W:0]        level;
  logic                   overflow;
  logic                   ovf_clr;
  logic [UART_DATA_W-1:0] uart_din;
  logic                   uart_wr_en;
  logic                   uart_tx_busy;

  modport master (
    output wr_data, wr_valid, ovf_clr, uart_tx_busy,
    input  wr_ready, level, overflow, uart_din, uart_wr_en
  );

  modport slave (
    input  wr_data, wr_valid, ovf_clr, uart_tx_busy,
    output wr_ready, level, overflow, uart_din, uart_wr_en
  );

endinterface

// File: rtl/pes_sync_fifo.sv
// Generic single-clock FIFO; pushes while full and pops while empty are ignored.
module pes_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  push_data_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  pop_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pes_uart_tx_fifo.sv
// Byte FIFO in front of the uart transmitter, draining one frame at a time
// and tracking tx_busy so only one byte is ever in flight.
module pes_uart_tx_fifo
  import pes_uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clk_50m,
  input  logic                rst,
  pes_uart_tx_fifo_if.slave   bus
);

  logic                   fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [UART_DATA_W-1:0] fifo_rd_data;
  logic [ADDR_W:0]        fifo_count;

  drain_state_e           state_q, state_d;
  logic [UART_DATA_W-1:0] din_q, din_d;
  logic                   wr_en_q, wr_en_d;
  logic                   ovf_q, ovf_d;

  // Acceptance uses the registered full flag, so a same-cycle pop never frees a slot.
  assign fifo_push = bus.wr_valid && !fifo_full;

  pes_sync_fifo #(
    .DEPTH  (DEPTH),
    .WIDTH  (UART_DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk         (clk_50m),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (bus.wr_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    wr_en_d  = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !bus.uart_tx_busy) begin
          din_d    = fifo_rd_data;
          wr_en_d  = 1'b1;
          fifo_pop = 1'b1;
          state_d  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.uart_tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!bus.uart_tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new overflow event takes priority over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.wr_valid && fifo_full) ovf_d = 1'b1;
    else if (bus.ovf_clr)          ovf_d = 1'b0;
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q <= IDLE;
      din_q   <= '0;
      wr_en_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      wr_en_q <= wr_en_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.wr_ready   = !fifo_full;
  assign bus.level      = fifo_count;
  assign bus.overflow   = ovf_q;
  assign bus.uart_din   = din_q;
  assign bus.uart_wr_en = wr_en_q;

endmodule

// File: tb/tb_pes_uart_tx_fifo.sv
// Randomized bench for pes_uart_tx_fifo with a queue-based reference and a simple uart busy model.
module tb_pes_uart_tx_fifo;
  import pes_uart_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk_50m = 1'b0;
  logic rst;
  always #10 clk_50m = ~clk_50m;

  pes_uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  pes_uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: byte queue plus "frame in flight" bookkeeping.
  logic [7:0] m_q[$];
  logic       m_inflight = 1'b0;
  logic       m_acked    = 1'b0;
  logic       m_ovf      = 1'b0;
  logic [7:0] m_din      = 8'h00;
  logic [7:0] out_log[$];

  // uart model: busy rises ack_dly cycles after a wr_en pulse and lasts frame_len cycles.
  int   ack_dly   = 1;
  int   frame_len = 10;
  int   pend      = 0;
  int   busy_cnt  = 0;
  logic ext_busy  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic clr, input logic r);
    logic busy_now;
    logic exp_wren;
    logic was_full;
    busy_now = (busy_cnt > 0) || ext_busy;
    rst              = r;
    bus.wr_valid     = v;
    bus.wr_data      = d;
    bus.ovf_clr      = clr;
    bus.uart_tx_busy = busy_now;
    exp_wren = 1'b0;
    if (r) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_acked    = 1'b0;
      m_ovf      = 1'b0;
      m_din      = 8'h00;
    end else begin
      was_full = (m_q.size() == DEPTH);
      if (!m_inflight && m_q.size() > 0 && !busy_now) begin
        m_din      = m_q.pop_front();
        exp_wren   = 1'b1;
        m_inflight = 1'b1;
        m_acked    = 1'b0;
      end else if (m_inflight && !m_acked && busy_now) begin
        m_acked = 1'b1;
      end else if (m_inflight && m_acked && !busy_now) begin
        m_inflight = 1'b0;
      end
      if (v && !was_full) m_q.push_back(d);
      if (v && was_full) m_ovf = 1'b1;
      else if (clr)      m_ovf = 1'b0;
    end
    @(posedge clk_50m);
    #1;
    check("wr_en",    32'(bus.uart_wr_en), 32'(exp_wren));
    check("din",      32'(bus.uart_din),   32'(m_din));
    check("level",    32'(bus.level),      32'(m_q.size()));
    check("wr_ready", 32'(bus.wr_ready),   32'(m_q.size() < DEPTH));
    check("overflow", 32'(bus.overflow),   32'(m_ovf));
    if (pend > 0) begin
      pend--;
      if (pend == 0) busy_cnt = frame_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    if (bus.uart_wr_en) begin
      out_log.push_back(bus.uart_din);
      pend = ack_dly;
      $display("issue byte %02h level %0d t=%0t", bus.uart_din, bus.level, $time);
    end
    @(negedge clk_50m);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus.wr_valid     = 1'b0;
    bus.wr_data      = 8'h00;
    bus.ovf_clr      = 1'b0;
    bus.uart_tx_busy = 1'b0;
    @(negedge clk_50m);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Single byte with an idle uart.
    frame_len = 10;
    out_log.delete();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    check("t1_level_after_push", 32'(bus.level), 32'd1);
    repeat (20) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("t1_pulses", 32'(out_log.size()), 32'd1);
    if (out_log.size() > 0) check("t1_byte", 32'(out_log[0]), 32'hA5);

    // Burst ordering with long frames.
    frame_len = 100;
    out_log.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    repeat (16 * 104 + 20) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("t2_pulses", 32'(out_log.size()), 32'd16);
    for (int i = 0; i < out_log.size() && i < 16; i++) check("t2_order", 32'(out_log[i]), 32'(i));

    // Fill under external busy, overflow, clear, then release.
    ext_busy  = 1'b1;
    frame_len = 3;
    out_log.delete();
    for (int i = 0; i < 17; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    check("t3_level_full", 32'(bus.level), 32'd16);
    check("t3_ready_low",  32'(bus.wr_ready), 32'd0);
    check("t3_ovf_set",    32'(bus.overflow), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t3_ovf_clr",    32'(bus.overflow), 32'd0);
    repeat (5) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("t3_holdoff",    32'(out_log.size()), 32'd0);
    ext_busy = 1'b0;
    repeat (16 * 7 + 20) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("t3_pulses", 32'(out_log.size()), 32'd16);
    if (out_log.size() > 0) check("t3_last", 32'(out_log[out_log.size()-1]), 32'h1F);

    // Reset during WAIT_DONE with five bytes queued.
    frame_len = 20;
    out_log.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("t4_level5", 32'(bus.level), 32'd5);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t4_rst_level", 32'(bus.level), 32'd0);
    check("t4_rst_ready", 32'(bus.wr_ready), 32'd1);
    repeat (60) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("t4_no_more", 32'(out_log.size()), 32'd1);

    // Randomized traffic with varying frames, hold-off, clears and rare resets.
    for (int c = 0; c < 2500; c++) begin
      logic v, clr, r;
      frame_len = $urandom_range(1, 8);
      ack_dly   = $urandom_range(1, 3);
      if ($urandom_range(0, 39) == 0) ext_busy = ~ext_busy;
      v   = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 19) == 0);
      r   = ($urandom_range(0, 399) == 0);
      step(v, 8'($urandom), clr, r);
    end
    ext_busy = 1'b0;
    repeat (200) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("final_empty", 32'(bus.level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
